// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared MIPS encoding constants for the ID stage: opcode and funct values,
// instruction field positions, a decoded-field struct and small helpers.
// Imported by instruction_decode.
// -----------------------------------------------------------------------------
package mips_pkg;

  // Instruction field positions
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;
  localparam int SH_MSB = 10;
  localparam int SH_LSB = 6;
  localparam int FN_MSB = 5;
  localparam int FN_LSB = 0;

  typedef logic [5:0] opcode_t;
  typedef logic [5:0] funct_t;

  localparam opcode_t OP_RTYPE = 6'b000000;
  localparam opcode_t OP_J     = 6'b000010;
  localparam opcode_t OP_JAL   = 6'b000011;
  localparam opcode_t OP_BEQ   = 6'b000100;
  localparam opcode_t OP_BNE   = 6'b000101;
  localparam opcode_t OP_LW    = 6'b100011;
  localparam opcode_t OP_SW    = 6'b101011;
  localparam opcode_t OP_ANDI  = 6'b001100;
  localparam opcode_t OP_ORI   = 6'b001101;
  localparam opcode_t OP_XORI  = 6'b001110;

  localparam funct_t FN_JR   = 6'b001000;
  localparam funct_t FN_JALR = 6'b001001;

  typedef struct packed {
    opcode_t    opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    funct_t     funct;
  } instr_fields_t;

  function automatic instr_fields_t split_instr(input logic [31:0] ir);
    instr_fields_t f;
    f.opcode = ir[OP_MSB:OP_LSB];
    f.rs     = ir[RS_MSB:RS_LSB];
    f.rt     = ir[RT_MSB:RT_LSB];
    f.rd     = ir[RD_MSB:RD_LSB];
    f.shamt  = ir[SH_MSB:SH_LSB];
    f.funct  = ir[FN_MSB:FN_LSB];
    return f;
  endfunction

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic is_zero_ext(input opcode_t op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

  // All stores share the 101xxx opcode group (SB, SH, SWL, SW, SWR).
  function automatic logic is_store(input opcode_t op);
    return op[5:3] == OP_SW[5:3];
  endfunction

endpackage

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// 32-entry general-purpose register file for the ID stage.
//   i_clock, i_reset      : clock, synchronous active-high reset (clears all)
//   we, wr_addr, wr_data  : writeback port (writes to r0 are dropped)
//   rd_addr_a/b, rd_data_a/b : combinational reads with write-through bypass
// Optional (REGFILE_DEBUG_EN): dbg_addr/dbg_data, unbypassed debug read.
// -----------------------------------------------------------------------------
module register_file #(
  parameter int NB_REG      = 32,
  parameter int N_REGS      = 32,
  parameter int NB_REG_ADDR = 5
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   we,
  input  logic [NB_REG_ADDR-1:0] wr_addr,
  input  logic [NB_REG-1:0]      wr_data,
  input  logic [NB_REG_ADDR-1:0] rd_addr_a,
  input  logic [NB_REG_ADDR-1:0] rd_addr_b,
  output logic [NB_REG-1:0]      rd_data_a,
  output logic [NB_REG-1:0]      rd_data_b
`ifdef REGFILE_DEBUG_EN
  ,
  input  logic [NB_REG_ADDR-1:0] dbg_addr,
  output logic [NB_REG-1:0]      dbg_data
`endif
);

  logic [NB_REG-1:0] words [N_REGS];

  genvar gi;
  generate
    for (gi = 0; gi < N_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        // r0 is hardwired; no storage is built for it.
        assign words[gi] = '0;
      end else begin : g_word
        localparam logic [NB_REG_ADDR-1:0] ADDR = NB_REG_ADDR'(gi);
        logic [NB_REG-1:0] word_reg;
        always_ff @(posedge i_clock) begin
          if (i_reset) begin
            word_reg <= '0;
          end else if (we && (wr_addr == ADDR)) begin
            word_reg <= wr_data;
          end
        end
        assign words[gi] = word_reg;
      end
    end
  endgenerate

  // Same-cycle writeback is forwarded so ID never sees a stale operand.
  assign rd_data_a = (we && (wr_addr == rd_addr_a) && (rd_addr_a != '0)) ? wr_data : words[rd_addr_a];
  assign rd_data_b = (we && (wr_addr == rd_addr_b) && (rd_addr_b != '0)) ? wr_data : words[rd_addr_b];

`ifdef REGFILE_DEBUG_EN
  assign dbg_data = words[dbg_addr];
`endif

endmodule

// File: rtl/instruction_decode.sv
// -----------------------------------------------------------------------------
// instruction_decode
// ID stage of the 5-stage MIPS pipeline. Reads operands, resolves jumps and
// branches, detects load-use / branch-operand hazards and drives the ID/EX
// pipeline register.
//   i_clock, i_reset   : clock, synchronous active-high reset
//   i_valid            : pipeline advance enable
//   i_ir, i_pc         : instruction and PC+4 from fetch
//   i_wb_*             : writeback port into the register file
//   i_ex_*             : EX-stage info for hazard detection
//   o_inm_i/o_inm_j/o_rs, o_jump_inm/o_jump_rs/o_branch, o_nop_reg : to fetch
//   o_stall            : hazard, fetch advance is gated with it
//   o_pc .. o_funct    : ID/EX pipeline register
// Optional macro REGFILE_DEBUG_EN adds i_dbg_addr/o_dbg_data (raw regfile read).
// -----------------------------------------------------------------------------
module instruction_decode
  import mips_pkg::*;
#(
  parameter int NB_REG      = 32,
  parameter int NB_INSTR    = 32,
  parameter int N_REGS      = 32,
  parameter int NB_REG_ADDR = 5,
  parameter int NB_INM_I    = 16,
  parameter int NB_INM_J    = 26
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic [NB_INSTR-1:0]    i_ir,
  input  logic [NB_REG-1:0]      i_pc,
  input  logic                   i_wb_we,
  input  logic [NB_REG_ADDR-1:0] i_wb_addr,
  input  logic [NB_REG-1:0]      i_wb_data,
  input  logic                   i_ex_mem_read,
  input  logic                   i_ex_reg_write,
  input  logic [NB_REG_ADDR-1:0] i_ex_rt_addr,
  output logic [NB_INM_I-1:0]    o_inm_i,
  output logic [NB_INM_J-1:0]    o_inm_j,
  output logic [NB_REG-1:0]      o_rs,
  output logic                   o_jump_inm,
  output logic                   o_jump_rs,
  output logic                   o_branch,
  output logic                   o_nop_reg,
  output logic                   o_stall,
  output logic [NB_REG-1:0]      o_pc,
  output logic [NB_REG-1:0]      o_rs_data,
  output logic [NB_REG-1:0]      o_rt_data,
  output logic [NB_REG-1:0]      o_imm_ext,
  output logic [NB_REG_ADDR-1:0] o_rs_addr,
  output logic [NB_REG_ADDR-1:0] o_rt_addr,
  output logic [NB_REG_ADDR-1:0] o_rd_addr,
  output logic [4:0]             o_shamt,
  output logic [5:0]             o_opcode,
  output logic [5:0]             o_funct
`ifdef REGFILE_DEBUG_EN
  ,
  input  logic [NB_REG_ADDR-1:0] i_dbg_addr,
  output logic [NB_REG-1:0]      o_dbg_data
`endif
);

  instr_fields_t     fields;
  logic [NB_REG-1:0] rs_val;
  logic [NB_REG-1:0] rt_val;
  logic [NB_REG-1:0] imm_ext;
  logic is_beq, is_bne, is_br, is_jr, reads_rt, advance;
  logic load_use, branch_hz;

  assign fields = split_instr(i_ir[31:0]);

  register_file #(
    .NB_REG      (NB_REG),
    .N_REGS      (N_REGS),
    .NB_REG_ADDR (NB_REG_ADDR)
  ) u_regs (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .we        (i_wb_we),
    .wr_addr   (i_wb_addr),
    .wr_data   (i_wb_data),
    .rd_addr_a (fields.rs),
    .rd_addr_b (fields.rt),
    .rd_data_a (rs_val),
    .rd_data_b (rt_val)
`ifdef REGFILE_DEBUG_EN
    ,
    .dbg_addr  (i_dbg_addr),
    .dbg_data  (o_dbg_data)
`endif
  );

  assign is_beq   = (fields.opcode == OP_BEQ);
  assign is_bne   = (fields.opcode == OP_BNE);
  assign is_br    = is_beq || is_bne;
  assign is_jr    = (fields.opcode == OP_RTYPE) && ((fields.funct == FN_JR) || (fields.funct == FN_JALR));
  assign reads_rt = (fields.opcode == OP_RTYPE) || is_br || is_store(fields.opcode);

  // A load in EX cannot forward into EX in time for a dependent instruction.
  assign load_use = i_ex_mem_read && (i_ex_rt_addr != '0) &&
                    ((i_ex_rt_addr == fields.rs) || (reads_rt && (i_ex_rt_addr == fields.rt)));

  // Branches/JR resolve in ID, so any result still in EX must be waited for.
  assign branch_hz = (is_br || is_jr) && i_ex_reg_write && (i_ex_rt_addr != '0) &&
                     ((i_ex_rt_addr == fields.rs) || (is_br && (i_ex_rt_addr == fields.rt)));

  assign o_stall = load_use || branch_hz;
  assign advance = i_valid && !o_stall;

  assign o_inm_i    = i_ir[NB_INM_I-1:0];
  assign o_inm_j    = i_ir[NB_INM_J-1:0];
  assign o_rs       = rs_val;
  assign o_jump_inm = advance && ((fields.opcode == OP_J) || (fields.opcode == OP_JAL));
  assign o_jump_rs  = advance && is_jr;
  assign o_branch   = advance && ((is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val)));

  assign imm_ext = is_zero_ext(fields.opcode) ?
                   {{(NB_REG-NB_INM_I){1'b0}}, i_ir[NB_INM_I-1:0]} :
                   {{(NB_REG-NB_INM_I){i_ir[NB_INM_I-1]}}, i_ir[NB_INM_I-1:0]};

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_nop_reg <= 1'b0;
      o_pc      <= '0;
      o_rs_data <= '0;
      o_rt_data <= '0;
      o_imm_ext <= '0;
      o_rs_addr <= '0;
      o_rt_addr <= '0;
      o_rd_addr <= '0;
      o_shamt   <= '0;
      o_opcode  <= '0;
      o_funct   <= '0;
    end else if (i_valid) begin
      // The instruction fetched behind a redirect is the one squashed.
      o_nop_reg <= o_jump_inm || o_jump_rs || o_branch;
      if (o_stall) begin
        o_pc      <= '0;
        o_rs_data <= '0;
        o_rt_data <= '0;
        o_imm_ext <= '0;
        o_rs_addr <= '0;
        o_rt_addr <= '0;
        o_rd_addr <= '0;
        o_shamt   <= '0;
        o_opcode  <= '0;
        o_funct   <= '0;
      end else begin
        o_pc      <= i_pc;
        o_rs_data <= rs_val;
        o_rt_data <= rt_val;
        o_imm_ext <= imm_ext;
        o_rs_addr <= fields.rs;
        o_rt_addr <= fields.rt;
        o_rd_addr <= fields.rd;
        o_shamt   <= fields.shamt;
        o_opcode  <= fields.opcode;
        o_funct   <= fields.funct;
      end
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// -----------------------------------------------------------------------------
// tb_instruction_decode
// Scoreboard bench for instruction_decode: a driver applies one cycle of
// stimulus, derives the expected combinational and post-edge outputs from a
// behavioural model and queues them; a monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] ir = '0;
  logic [31:0] pc = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        ex_mr = 1'b0;
  logic        ex_rw = 1'b0;
  logic [4:0]  ex_rt = '0;

  logic [15:0] o_inm_i;
  logic [25:0] o_inm_j;
  logic [31:0] o_rs, o_pc, o_rs_data, o_rt_data, o_imm_ext;
  logic        o_jump_inm, o_jump_rs, o_branch, o_nop_reg, o_stall;
  logic [4:0]  o_rs_addr, o_rt_addr, o_rd_addr, o_shamt;
  logic [5:0]  o_opcode, o_funct;

  instruction_decode dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_valid        (valid),
    .i_ir           (ir),
    .i_pc           (pc),
    .i_wb_we        (wb_we),
    .i_wb_addr      (wb_addr),
    .i_wb_data      (wb_data),
    .i_ex_mem_read  (ex_mr),
    .i_ex_reg_write (ex_rw),
    .i_ex_rt_addr   (ex_rt),
    .o_inm_i        (o_inm_i),
    .o_inm_j        (o_inm_j),
    .o_rs           (o_rs),
    .o_jump_inm     (o_jump_inm),
    .o_jump_rs      (o_jump_rs),
    .o_branch       (o_branch),
    .o_nop_reg      (o_nop_reg),
    .o_stall        (o_stall),
    .o_pc           (o_pc),
    .o_rs_data      (o_rs_data),
    .o_rt_data      (o_rt_data),
    .o_imm_ext      (o_imm_ext),
    .o_rs_addr      (o_rs_addr),
    .o_rt_addr      (o_rt_addr),
    .o_rd_addr      (o_rd_addr),
    .o_shamt        (o_shamt),
    .o_opcode       (o_opcode),
    .o_funct        (o_funct)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] ir;
    logic [15:0] inm_i;
    logic [25:0] inm_j;
    logic [31:0] rs;
    logic        jimm, jrs, br, stall;
    logic [31:0] pc, rs_data, rt_data, imm_ext;
    logic [4:0]  rs_a, rt_a, rd_a, sh;
    logic [5:0]  op, fn;
    logic        nop;
  } txn_t;

  txn_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   ntx   = 0;

  // Behavioural model state: architectural registers plus the ID/EX latch.
  logic [31:0] m_regs [32];
  logic [31:0] m_pc, m_rsd, m_rtd, m_imm;
  logic [4:0]  m_rsa, m_rta, m_rda, m_sh;
  logic [5:0]  m_op, m_fn;
  logic        m_nop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int id);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL txn %0d %s: got %08h expected %08h", id, name, act, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a, input logic we, input logic [4:0] wa,
                                        input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                                        input logic [4:0] sh, input logic [5:0] f);
    return {6'd0, s, t, d, sh, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                        input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  // Drive one cycle, predict the outcome, queue it and advance the model.
  task automatic cycle(input logic r, input logic v, input logic [31:0] instr, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd, input logic mr,
                       input logic rw, input logic [4:0] xrt);
    txn_t t;
    logic [5:0]  op, fn;
    logic [4:0]  s, d;
    logic [31:0] sv, dv, p, ext;
    logic        br_op, jr_op, uses_rt, st, go;
    p = $urandom;
    @(negedge clk);
    rst = r; valid = v; ir = instr; pc = p;
    wb_we = we; wb_addr = wa; wb_data = wd;
    ex_mr = mr; ex_rw = rw; ex_rt = xrt;
    #1;
    op = instr[31:26]; s = instr[25:21]; d = instr[20:16]; fn = instr[5:0];
    sv = mread(s, we, wa, wd);
    dv = mread(d, we, wa, wd);
    br_op   = (op == 6'h04) || (op == 6'h05);
    jr_op   = (op == 6'h00) && (fn == 6'h08 || fn == 6'h09);
    uses_rt = (op == 6'h00) || br_op || op == 6'h28 || op == 6'h29 || op == 6'h2a ||
              op == 6'h2b || op == 6'h2e;
    st = (mr && xrt != 0 && (xrt == s || (uses_rt && xrt == d))) ||
         ((br_op || jr_op) && rw && xrt != 0 && (xrt == s || (br_op && xrt == d)));
    go = v && !st;
    if (op == 6'h0c || op == 6'h0d || op == 6'h0e) ext = {16'h0000, instr[15:0]};
    else ext = 32'(signed'(instr[15:0]));

    t.id    = ntx++;
    t.ir    = instr;
    t.inm_i = instr[15:0];
    t.inm_j = instr[25:0];
    t.rs    = sv;
    t.stall = st;
    t.jimm  = go && (op == 6'h02 || op == 6'h03);
    t.jrs   = go && jr_op;
    t.br    = go && ((op == 6'h04 && sv == dv) || (op == 6'h05 && sv != dv));

    if (r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_pc = '0; m_rsd = '0; m_rtd = '0; m_imm = '0;
      m_rsa = '0; m_rta = '0; m_rda = '0; m_sh = '0; m_op = '0; m_fn = '0; m_nop = 1'b0;
    end else begin
      if (we && wa != 0) m_regs[wa] = wd;
      if (v) begin
        m_nop = t.jimm || t.jrs || t.br;
        if (st) begin
          m_pc = '0; m_rsd = '0; m_rtd = '0; m_imm = '0;
          m_rsa = '0; m_rta = '0; m_rda = '0; m_sh = '0; m_op = '0; m_fn = '0;
        end else begin
          m_pc = p; m_rsd = sv; m_rtd = dv; m_imm = ext;
          m_rsa = s; m_rta = d; m_rda = instr[15:11]; m_sh = instr[10:6]; m_op = op; m_fn = fn;
        end
      end
    end
    t.pc = m_pc; t.rs_data = m_rsd; t.rt_data = m_rtd; t.imm_ext = m_imm;
    t.rs_a = m_rsa; t.rt_a = m_rta; t.rd_a = m_rda; t.sh = m_sh; t.op = m_op; t.fn = m_fn;
    t.nop = m_nop;
    sb_q.push_back(t);
  endtask

  // Monitor: combinational outputs mid-cycle, registered outputs after the edge.
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        t = sb_q.pop_front();
        chk("inm_i",    32'(o_inm_i),    32'(t.inm_i), t.id);
        chk("inm_j",    32'(o_inm_j),    32'(t.inm_j), t.id);
        chk("rs",       o_rs,            t.rs,         t.id);
        chk("jump_inm", 32'(o_jump_inm), 32'(t.jimm),  t.id);
        chk("jump_rs",  32'(o_jump_rs),  32'(t.jrs),   t.id);
        chk("branch",   32'(o_branch),   32'(t.br),    t.id);
        chk("stall",    32'(o_stall),    32'(t.stall), t.id);
        @(posedge clk);
        #1;
        chk("pc",       o_pc,            t.pc,         t.id);
        chk("rs_data",  o_rs_data,       t.rs_data,    t.id);
        chk("rt_data",  o_rt_data,       t.rt_data,    t.id);
        chk("imm_ext",  o_imm_ext,       t.imm_ext,    t.id);
        chk("rs_addr",  32'(o_rs_addr),  32'(t.rs_a),  t.id);
        chk("rt_addr",  32'(o_rt_addr),  32'(t.rt_a),  t.id);
        chk("rd_addr",  32'(o_rd_addr),  32'(t.rd_a),  t.id);
        chk("shamt",    32'(o_shamt),    32'(t.sh),    t.id);
        chk("opcode",   32'(o_opcode),   32'(t.op),    t.id);
        chk("funct",    32'(o_funct),    32'(t.fn),    t.id);
        chk("nop_reg",  32'(o_nop_reg),  32'(t.nop),   t.id);
        $display("txn %0d ir=%08h stall=%0b br=%0b ji=%0b jr=%0b nop=%0b",
                 t.id, t.ir, t.stall, t.br, t.jimm, t.jrs, t.nop);
      end
    end
  end

  initial begin
    logic [5:0]  op;
    logic [31:0] instr;
    logic [4:0]  a, b, c;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc = '0; m_rsd = '0; m_rtd = '0; m_imm = '0;
    m_rsa = '0; m_rta = '0; m_rda = '0; m_sh = '0; m_op = '0; m_fn = '0; m_nop = 1'b0;

    // Unchecked power-on reset so the DUT leaves its X state.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);

    // Directed sequence
    cycle(1, 0, 32'h0, 0, 0, 0, 0, 0, 0);                              // reset state
    cycle(0, 1, 32'h0, 1, 5, 32'h0000_1234, 0, 0, 0);                  // r5 = 0x1234
    cycle(0, 1, enc_r(5, 0, 1, 0, 6'h20), 0, 0, 0, 0, 0, 0);           // ADD r1,r5,r0
    cycle(0, 1, enc_r(0, 6, 2, 0, 6'h20), 1, 6, 32'h0000_00AA, 0, 0, 0); // bypass r6
    cycle(0, 1, 32'h0, 1, 1, 32'd7, 0, 0, 0);
    cycle(0, 1, 32'h0, 1, 2, 32'd7, 0, 0, 0);
    cycle(0, 1, enc_i(6'h04, 1, 2, 16'h0003), 0, 0, 0, 0, 0, 0);       // BEQ taken
    cycle(0, 1, enc_r(1, 2, 3, 0, 6'h20), 0, 0, 0, 0, 0, 0);           // squashed slot
    cycle(0, 1, 32'h0, 0, 0, 0, 0, 0, 0);                              // nop_reg drops
    cycle(0, 1, 32'h0, 1, 31, 32'h0000_0040, 0, 0, 0);
    cycle(0, 1, enc_r(31, 0, 0, 0, 6'h08), 0, 0, 0, 0, 0, 0);          // JR r31
    cycle(0, 1, enc_j(6'h02, 26'h100), 0, 0, 0, 0, 0, 0);              // J 0x100
    cycle(0, 1, enc_r(3, 0, 4, 0, 6'h20), 0, 0, 0, 1, 1, 3);           // load-use stall
    cycle(0, 1, enc_r(3, 0, 4, 0, 6'h20), 0, 0, 0, 1, 1, 0);           // EX rt = r0
    cycle(0, 0, enc_i(6'h08, 1, 1, 16'h5555), 0, 0, 0, 0, 0, 0);       // hold
    cycle(0, 1, enc_i(6'h0d, 0, 1, 16'h8000), 0, 0, 0, 0, 0, 0);       // ORI
    cycle(0, 1, enc_i(6'h08, 0, 1, 16'h8000), 0, 0, 0, 0, 0, 0);       // ADDI
    cycle(0, 1, 32'h0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0);                  // write r0
    cycle(0, 1, enc_r(0, 0, 1, 0, 6'h20), 0, 0, 0, 0, 0, 0);           // r0 reads 0
    cycle(0, 1, enc_i(6'h04, 1, 2, 16'h0010), 0, 0, 0, 0, 0, 0);       // BEQ taken
    cycle(1, 1, enc_r(3, 0, 4, 0, 6'h20), 0, 0, 0, 1, 1, 3);           // reset mid-stall
    cycle(0, 1, 32'h0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 300; n++) begin
      a = 5'($urandom_range(0, 7));
      b = 5'($urandom_range(0, 7));
      c = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 12))
        0:  instr = 32'h0;
        1:  instr = enc_r(a, b, c, 5'($urandom_range(0, 31)), 6'h20);
        2:  instr = enc_r(a, b, c, 0, 6'h22);
        3:  instr = enc_j(6'h02, 26'($urandom));
        4:  instr = enc_j(6'h03, 26'($urandom));
        5:  instr = enc_r(a, 0, 0, 0, 6'h08);
        6:  instr = enc_r(a, 0, 31, 0, 6'h09);
        7:  instr = enc_i(6'h04, a, b, 16'($urandom));
        8:  instr = enc_i(6'h05, a, b, 16'($urandom));
        9:  instr = enc_i(6'h23, a, b, 16'($urandom));
        10: instr = enc_i(6'h2b, a, b, 16'($urandom));
        11: begin
          op = 6'($urandom_range(12, 14));
          instr = enc_i(op, a, b, 16'($urandom));
        end
        default: instr = enc_i(6'h08, a, b, 16'($urandom));
      endcase
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0), instr,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 32'($urandom_range(0, 3)),
            $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)));
    end

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending transactions expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- ID stage of the 5-stage MIPS pipeline.
- Consumes fetch's registered instruction and PC+4, holds the 32x32 register file, and resolves jumps and branches in ID.
- Drives fetch's redirect inputs: inm_i, inm_j, rs value, jump_inm, jump_rs, branch, nop_reg.
- Registers decoded operands into the ID/EX pipeline register and detects load-use and branch-operand hazards.

Parameters:
- NB_REG, 32, register/data width
- NB_INSTR, 32, instruction width
- N_REGS, 32, register file depth
- NB_REG_ADDR, 5, register address width
- NB_INM_I, 16, I-type immediate width
- NB_INM_J, 26, J-type target width

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  pipeline advance enable
- i_ir  in  NB_INSTR  instruction from fetch (0 = NOP)
- i_pc  in  NB_REG  PC+4 from fetch
- i_wb_we  in  1  writeback enable
- i_wb_addr  in  NB_REG_ADDR  writeback register
- i_wb_data  in  NB_REG  writeback data
- i_ex_mem_read  in  1  instruction in EX is a load
- i_ex_reg_write  in  1  instruction in EX writes a register
- i_ex_rt_addr  in  NB_REG_ADDR  destination of instruction in EX
- o_inm_i  out  NB_INM_I  i_ir[15:0], combinational
- o_inm_j  out  NB_INM_J  i_ir[25:0], combinational
- o_rs  out  NB_REG  bypassed rs value, combinational
- o_jump_inm  out  1  J/JAL taken
- o_jump_rs  out  1  JR/JALR taken
- o_branch  out  1  BEQ/BNE taken
- o_nop_reg  out  1  squash next fetched instruction
- o_stall  out  1  hazard; top gates fetch i_valid with it
- o_pc  out  NB_REG  ID/EX PC+4
- o_rs_data  out  NB_REG  ID/EX rs value
- o_rt_data  out  NB_REG  ID/EX rt value
- o_imm_ext  out  NB_REG  ID/EX extended immediate
- o_rs_addr, o_rt_addr, o_rd_addr  out  NB_REG_ADDR  ID/EX register fields
- o_shamt  out  5  ID/EX shift amount
- o_opcode  out  6  ID/EX opcode
- o_funct  out  6  ID/EX funct

Behaviour:
- Reset: all ID/EX outputs 0; o_nop_reg 0; register file cleared to 0.
- Register file:
  - r0 always reads 0 and ignores writes.
  - Write on posedge when i_wb_we and i_wb_addr != 0, independent of i_valid.
  - Reads are combinational with write-through bypass: if i_wb_we and i_wb_addr == the read address (nonzero), return i_wb_data.
- Decode (combinational, gated by i_valid and !o_stall):
  - J (000010), JAL (000011) -> o_jump_inm.
  - R-type with funct JR (001000) or JALR (001001) -> o_jump_rs.
  - BEQ (000100) with rs == rt, or BNE (000101) with rs != rt -> o_branch.
  - At most one control output is high at a time.
- o_stall, combinational, high when either:
  - load-use: i_ex_mem_read and i_ex_rt_addr != 0 and it matches rs, or rt (rt only for R-type/BEQ/BNE/stores);
  - branch operand: current instruction is BEQ/BNE/JR/JALR and i_ex_reg_write and i_ex_rt_addr != 0 and it matches a source it reads.
- ID/EX register (posedge, when i_valid):
  - If o_stall, load a bubble (all fields 0); otherwise load the decoded fields.
  - o_imm_ext is zero-extended for ANDI/ORI/XORI (001100/001101/001110); sign-extended for all other opcodes.
  - When i_valid is low, all outputs hold.
- o_nop_reg:
  - Set to 1 on a valid cycle in which any of o_jump_inm, o_jump_rs, o_branch is high; otherwise 0.
  - Holds when i_valid is low.
  - Squashes exactly one instruction.
- NOP input (i_ir = 0) decodes as SLL r0,r0,0: no control outputs asserted, no stall.
- Reset mid-stall: the reset takes priority and clears all registers.

Optional Feature:
- Macro REGFILE_DEBUG_EN.
- Defined: adds ports i_dbg_addr (in, NB_REG_ADDR) and o_dbg_data (out, NB_REG).
  - o_dbg_data is a combinational, unbypassed read of the register file, for the debug unit.
- Undefined: ports absent, no extra logic.

Decomposition:
- Package mips_pkg holds:
  - opcode constants: OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_ANDI, OP_ORI, OP_XORI;
  - funct constants: FN_JR, FN_JALR;
  - field-position localparams.
- One sub-module, register_file: storage, r0 handling, write-through bypass, optional debug port.

Test Plan:
- Write r5=0x0000_1234 via WB, then ir=ADD r1,r5,r0 -> next cycle o_rs_data=0x1234; same-cycle WB r6=0xAA with ir reading r6 -> o_rt_data=0xAA.
- r1=r2=7, ir=BEQ r1,r2,+3:
  - same cycle: o_branch=1, o_inm_i=0x0003;
  - next cycle: o_nop_reg=1;
  - the cycle after: o_nop_reg=0.
- ir=JR r31 with r31=0x40 -> o_jump_rs=1, o_rs=0x40; ir=J 0x100 -> o_jump_inm=1, o_inm_j=0x100.
- EX is LW to r3 (i_ex_mem_read=1, i_ex_rt_addr=3), ir=ADD r4,r3,r0 -> o_stall=1 and ID/EX bubble; with i_ex_rt_addr=0 -> no stall.
- ORI imm 0x8000 -> o_imm_ext=0x0000_8000; ADDI imm 0x8000 -> 0xFFFF_8000.
- Write r0=0xFFFF_FFFF -> r0 still reads 0; assert reset mid-stall -> all outputs 0, o_nop_reg=0.
